ring_code_checker: RTL and testbench
====================================

# ring_code_checker

Receive-side checker and decoder for the one-hot ring counter code. It samples a WIDTH-bit ring word each qualified cycle and decodes the hot position to a binary index. It verifies that each word is exactly one-hot and is the one-step rotation of the previous word, and it reports lock status and error pulses. It sits downstream of any ring counter, such as a sequencer phase bus, and monitors its integrity.

## Interface
Parameters:
- WIDTH, 4, ring word width; at least 2
- IDX_W, 2, index width; must equal clog2(WIDTH)
- LOCK_CNT, 2, number of consecutive correct rotations needed to declare lock; at least 1
- ERR_W, 8, width of the saturating error counter

Ports:
- clk  input  1  single clock; all logic on rising edge
- rst  input  1  synchronous, active-high reset
- in_q  input  WIDTH  ring word under test
- in_valid  input  1  in_q is sampled this cycle when high
- err_clr  input  1  synchronous clear of err_count
- idx  output  IDX_W  binary position of the hot bit of the last valid one-hot sample
- idx_valid  output  1  one-cycle pulse: idx updated from a one-hot sample
- locked  output  1  high while the FSM is in LOCKED
- err_onehot  output  1  one-cycle pulse: a valid sample was not one-hot
- err_seq  output  1  one-cycle pulse: a one-hot sample broke the rotation while LOCKED
- err_count  output  ERR_W  saturating count of err_onehot and err_seq events

## Operation
- Expected next word: rot(prev) = {prev[WIDTH-2:0], prev[WIDTH-1]}. Example: 0001 → 0010 → 0100 → 1000 → 0001.
- onehot(x): exactly one bit of x is set. All-zero and multi-hot words are illegal.
- Internal registers: state, prev (WIDTH bits), good_cnt (counts 0 to LOCK_CNT).
- No-sample cycles: when in_valid = 0, state, prev, good_cnt and idx hold. idx_valid, err_onehot and err_seq are 0.
- Every valid sample:
  - If onehot(in_q): idx ← position of the hot bit, idx_valid pulses, prev ← in_q.
  - If not onehot(in_q): err_onehot pulses in every state; idx and prev hold.
- FSM states and transitions (evaluated only on valid samples):
  - HUNT: one-hot sample → SYNC with good_cnt = 0. Non-one-hot sample → stay in HUNT.
  - SYNC:
    - in_q == rot(prev): good_cnt + 1; when the count reaches LOCK_CNT → LOCKED.
    - One-hot but wrong rotation: stay in SYNC, good_cnt = 0, new word becomes prev. No error pulse.
    - Non-one-hot → HUNT.
  - LOCKED:
    - in_q == rot(prev): stay in LOCKED.
    - One-hot but wrong rotation: err_seq pulses → SYNC, good_cnt = 0, new word becomes prev.
    - Non-one-hot: err_onehot only (never err_seq) → HUNT.
- err_seq and err_onehot are never high in the same cycle.
- err_count:
  - Increments by 1 on any error pulse.
  - Saturates at 2^ERR_W − 1.
  - err_clr has priority: if it coincides with an error, the count becomes 0.
- Wrap-around: 1000 → 0001 is a legal rotation.
- Repeated word (e.g. 0010 followed by 0010) is a rotation error.

## Timing
- Reset value of every output: idx = 0, idx_valid = 0, locked = 0, err_onehot = 0, err_seq = 0, err_count = 0.
- Reset value of internal state: state = HUNT, prev = 0, good_cnt = 0.
- rst has priority over every input, including mid-operation. In the first cycle after rst falls, the block is in HUNT and the prior lock is lost.
- All outputs are registered. Latency is one cycle: a sample on edge N is reflected in idx, idx_valid, the error pulses, locked and err_count immediately after edge N.
- Lock latency: with in_valid held high, locked asserts after the edge that samples the (LOCK_CNT+1)-th consecutive correct word (the 3rd word for LOCK_CNT = 2).
- locked deasserts after the edge that samples the offending word.

## Test plan
- Reset then lock: rst for 1 cycle, then in_q = 0001, 0010, 0100, 1000, 0001 on consecutive cycles with in_valid = 1.
  - idx = 0, 1, 2, 3, 0; idx_valid high each cycle.
  - locked rises after the 0100 sample.
  - No errors; err_count = 0.
- Rotation error while locked: after lock, present 0010 then 1000. err_seq pulses once, locked falls, err_count = 1. Continuing 0001, 0010 re-locks after the 0010 sample.
- Illegal words: while locked, present 0000 then 0110.
  - err_onehot pulses on each; err_seq stays 0; err_count = 2.
  - State is HUNT; idx holds its last value.
- in_valid gaps: while locked, drop in_valid for 3 cycles, then present the correct next word. locked stays high, no pulses, idx_valid is 0 during the gap.
- Saturation and clear: with ERR_W = 2, inject 5 non-one-hot words; err_count stops at 3. Assert err_clr together with a 6th bad word: err_count = 0 and err_onehot still pulses.
- Mid-run reset: assert rst while locked with a bad word on in_q. All outputs return to reset values, and a fresh 3-word correct sequence relocks.

Source files
------------

// File: rtl/ring_code_checker.sv
// ring_code_checker
// Receive-side checker for a one-hot ring counter bus. Each qualified sample
// is decoded to a binary index, checked for being exactly one-hot, and checked
// for being the one-step left rotation of the previous one-hot sample.
//
// Ports:
//   clk        - single clock, rising edge
//   rst        - synchronous active-high reset
//   in_q       - ring word under test (WIDTH bits)
//   in_valid   - sample in_q this cycle
//   err_clr    - synchronous clear of err_count (wins over a coincident error)
//   idx        - binary position of the hot bit of the last one-hot sample
//   idx_valid  - one-cycle pulse, idx updated this cycle
//   locked     - high while in LOCKED
//   err_onehot - one-cycle pulse, a valid sample was not one-hot
//   err_seq    - one-cycle pulse, rotation broken while LOCKED
//   err_count  - saturating count of error pulses
//
// state  | meaning
// -------+---------------------------------------------------------------
// HUNT   | no trusted previous word; waiting for any one-hot sample
// SYNC   | have a reference word; counting consecutive correct rotations
// LOCKED | LOCK_CNT correct rotations seen; rotation breaks are errors

module ring_code_checker #(
  parameter int WIDTH    = 4,
  parameter int IDX_W    = 2,
  parameter int LOCK_CNT = 2,
  parameter int ERR_W    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_q,
  input  logic             in_valid,
  input  logic             err_clr,
  output logic [IDX_W-1:0] idx,
  output logic             idx_valid,
  output logic             locked,
  output logic             err_onehot,
  output logic             err_seq,
  output logic [ERR_W-1:0] err_count
);

  localparam int CNT_W = $clog2(LOCK_CNT + 1);
  localparam logic [WIDTH-1:0] WORD_ONE = WIDTH'(1);

  typedef enum logic [1:0] {
    ST_HUNT   = 2'd0,
    ST_SYNC   = 2'd1,
    ST_LOCKED = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] prev_q, prev_d;
  logic [CNT_W-1:0] good_cnt_q, good_cnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             idx_valid_q, idx_valid_d;
  logic             locked_q, locked_d;
  logic             err_onehot_q, err_onehot_d;
  logic             err_seq_q, err_seq_d;
  logic [ERR_W-1:0] err_count_q, err_count_d;

  logic             is_onehot;
  logic             rot_match;
  logic [IDX_W-1:0] hot_idx;

  // x & (x-1) clears the lowest set bit, so it is zero only for <=1 bits set.
  assign is_onehot = (in_q != '0) && ((in_q & (in_q - WORD_ONE)) == '0);
  assign rot_match = (in_q == {prev_q[WIDTH-2:0], prev_q[WIDTH-1]});

  always_comb begin
    hot_idx = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (in_q[i]) hot_idx = IDX_W'(i);
    end
  end

  always_comb begin
    state_d      = state_q;
    prev_d       = prev_q;
    good_cnt_d   = good_cnt_q;
    idx_d        = idx_q;
    idx_valid_d  = 1'b0;
    err_onehot_d = 1'b0;
    err_seq_d    = 1'b0;
    err_count_d  = err_count_q;

    if (in_valid) begin
      if (is_onehot) begin
        idx_d       = hot_idx;
        idx_valid_d = 1'b1;
        prev_d      = in_q;
        case (state_q)
          ST_HUNT: begin
            state_d    = ST_SYNC;
            good_cnt_d = '0;
          end
          ST_SYNC: begin
            if (rot_match) begin
              good_cnt_d = good_cnt_q + CNT_W'(1);
              if (good_cnt_q == CNT_W'(LOCK_CNT - 1)) state_d = ST_LOCKED;
            end else begin
              good_cnt_d = '0;
            end
          end
          ST_LOCKED: begin
            if (!rot_match) begin
              err_seq_d  = 1'b1;
              state_d    = ST_SYNC;
              good_cnt_d = '0;
            end
          end
          default: begin
            state_d    = ST_HUNT;
            good_cnt_d = '0;
          end
        endcase
      end else begin
        err_onehot_d = 1'b1;
        state_d      = ST_HUNT;
        good_cnt_d   = '0;
      end
    end

    if (err_clr) begin
      err_count_d = '0;
    end else if ((err_onehot_d || err_seq_d) && (err_count_q != '1)) begin
      err_count_d = err_count_q + ERR_W'(1);
    end

    locked_d = (state_d == ST_LOCKED);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_HUNT;
      prev_q       <= '0;
      good_cnt_q   <= '0;
      idx_q        <= '0;
      idx_valid_q  <= 1'b0;
      locked_q     <= 1'b0;
      err_onehot_q <= 1'b0;
      err_seq_q    <= 1'b0;
      err_count_q  <= '0;
    end else begin
      state_q      <= state_d;
      prev_q       <= prev_d;
      good_cnt_q   <= good_cnt_d;
      idx_q        <= idx_d;
      idx_valid_q  <= idx_valid_d;
      locked_q     <= locked_d;
      err_onehot_q <= err_onehot_d;
      err_seq_q    <= err_seq_d;
      err_count_q  <= err_count_d;
    end
  end

  assign idx        = idx_q;
  assign idx_valid  = idx_valid_q;
  assign locked     = locked_q;
  assign err_onehot = err_onehot_q;
  assign err_seq    = err_seq_q;
  assign err_count  = err_count_q;

endmodule

// File: tb/tb_ring_code_checker.sv
// Bench for ring_code_checker: directed vectors, a behavioural model that
// tracks "streak of correct rotations since the last trusted one-hot word",
// a per-cycle compare process, and literal spot checks.

module tb_ring_code_checker;

  localparam int WIDTH    = 4;
  localparam int IDX_W    = 2;
  localparam int LOCK_CNT = 2;
  localparam int ERR_W    = 2;
  localparam int ERR_MAX  = (1 << ERR_W) - 1;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic [WIDTH-1:0] in_q = '0;
  logic             in_valid = 1'b0;
  logic             err_clr = 1'b0;
  logic [IDX_W-1:0] idx;
  logic             idx_valid;
  logic             locked;
  logic             err_onehot;
  logic             err_seq;
  logic [ERR_W-1:0] err_count;

  int total = 0;
  int bad   = 0;
  bit checking = 1'b0;

  ring_code_checker #(
    .WIDTH(WIDTH), .IDX_W(IDX_W), .LOCK_CNT(LOCK_CNT), .ERR_W(ERR_W)
  ) dut (
    .clk(clk), .rst(rst), .in_q(in_q), .in_valid(in_valid), .err_clr(err_clr),
    .idx(idx), .idx_valid(idx_valid), .locked(locked),
    .err_onehot(err_onehot), .err_seq(err_seq), .err_count(err_count)
  );

  always #5 clk = ~clk;

  // Model: tracking means a trusted reference word exists; streak counts
  // consecutive correct rotations; lock is simply streak >= LOCK_CNT.
  int m_idx = 0, m_pidx = 0, m_streak = 0, m_cnt = 0;
  bit m_track = 0, m_iv = 0, m_eo = 0, m_es = 0;

  always @(posedge clk) begin
    if (rst) begin
      m_idx = 0; m_pidx = 0; m_streak = 0; m_cnt = 0;
      m_track = 0; m_iv = 0; m_eo = 0; m_es = 0;
    end else begin
      m_iv = 0; m_eo = 0; m_es = 0;
      if (in_valid) begin
        if ($countones(in_q) == 1) begin
          int h;
          bit right;
          h = 0;
          for (int i = 0; i < WIDTH; i++) if (in_q[i]) h = i;
          right = (h == (m_pidx + 1) % WIDTH);
          m_iv  = 1;
          m_idx = h;
          if (!m_track) begin
            m_track  = 1;
            m_streak = 0;
          end else if (right) begin
            if (m_streak < LOCK_CNT) m_streak = m_streak + 1;
          end else begin
            m_es     = (m_streak >= LOCK_CNT);
            m_streak = 0;
          end
          m_pidx = h;
        end else begin
          m_eo     = 1;
          m_track  = 0;
          m_streak = 0;
        end
      end
      if (err_clr) m_cnt = 0;
      else if ((m_eo || m_es) && m_cnt < ERR_MAX) m_cnt = m_cnt + 1;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (checking) begin
      chk("cmp_idx",        int'(idx),        m_idx);
      chk("cmp_idx_valid",  int'(idx_valid),  int'(m_iv));
      chk("cmp_locked",     int'(locked),     int'(m_track && m_streak >= LOCK_CNT));
      chk("cmp_err_onehot", int'(err_onehot), int'(m_eo));
      chk("cmp_err_seq",    int'(err_seq),    int'(m_es));
      chk("cmp_err_count",  int'(err_count),  m_cnt);
      chk("cmp_err_excl",   int'(err_onehot && err_seq), 0);
    end
  end

  task automatic step(input logic r, input logic [WIDTH-1:0] w,
                      input logic v, input logic c);
    @(negedge clk);
    rst = r; in_q = w; in_valid = v; err_clr = c;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // reset
    step(1'b1, 4'b0000, 1'b0, 1'b0);
    checking = 1'b1;
    chk("rst_idx", int'(idx), 0);
    chk("rst_locked", int'(locked), 0);
    chk("rst_err_count", int'(err_count), 0);

    // lock sequence
    step(1'b0, 4'b0001, 1'b1, 1'b0);
    chk("l1_idx", int'(idx), 0); chk("l1_locked", int'(locked), 0);
    step(1'b0, 4'b0010, 1'b1, 1'b0);
    chk("l2_idx", int'(idx), 1); chk("l2_locked", int'(locked), 0);
    step(1'b0, 4'b0100, 1'b1, 1'b0);
    chk("l3_idx", int'(idx), 2); chk("l3_locked", int'(locked), 1);
    step(1'b0, 4'b1000, 1'b1, 1'b0);
    chk("l4_idx", int'(idx), 3);
    step(1'b0, 4'b0001, 1'b1, 1'b0);
    chk("l5_wrap_idx", int'(idx), 0); chk("l5_locked", int'(locked), 1);
    chk("l5_err_count", int'(err_count), 0);

    // rotation error while locked, then relock
    step(1'b0, 4'b0010, 1'b1, 1'b0);
    step(1'b0, 4'b1000, 1'b1, 1'b0);
    chk("rot_err_seq", int'(err_seq), 1); chk("rot_locked", int'(locked), 0);
    chk("rot_err_count", int'(err_count), 1);
    step(1'b0, 4'b0001, 1'b1, 1'b0);
    chk("rl1_locked", int'(locked), 0);
    step(1'b0, 4'b0010, 1'b1, 1'b0);
    chk("rl2_locked", int'(locked), 1);

    // in_valid gap
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 4'b1111, 1'b0, 1'b0);
      chk("gap_idx_valid", int'(idx_valid), 0);
      chk("gap_locked", int'(locked), 1);
    end
    step(1'b0, 4'b0100, 1'b1, 1'b0);
    chk("gap_next_idx", int'(idx), 2); chk("gap_next_locked", int'(locked), 1);

    // clear counter on a good word, then illegal words
    step(1'b0, 4'b1000, 1'b1, 1'b1);
    chk("clr_err_count", int'(err_count), 0);
    step(1'b0, 4'b0000, 1'b1, 1'b0);
    chk("zero_err_onehot", int'(err_onehot), 1); chk("zero_locked", int'(locked), 0);
    step(1'b0, 4'b0110, 1'b1, 1'b0);
    chk("multi_err_onehot", int'(err_onehot), 1); chk("multi_err_seq", int'(err_seq), 0);
    chk("multi_err_count", int'(err_count), 2); chk("multi_idx_hold", int'(idx), 3);
    // HUNT: a correctly rotated word still does not count toward lock
    step(1'b0, 4'b0001, 1'b1, 1'b0);
    step(1'b0, 4'b0010, 1'b1, 1'b0);
    chk("hunt_no_lock", int'(locked), 0);

    // saturation and clear priority
    step(1'b0, 4'b0000, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 4'b1100, 1'b1, 1'b0);
    end
    chk("sat_err_count", int'(err_count), 3);
    step(1'b0, 4'b1111, 1'b1, 1'b1);
    chk("sat_clr_count", int'(err_count), 0);
    chk("sat_clr_onehot", int'(err_onehot), 1);

    // lock then mid-run reset with a bad word present
    step(1'b0, 4'b0001, 1'b1, 1'b0);
    step(1'b0, 4'b0010, 1'b1, 1'b0);
    step(1'b0, 4'b0100, 1'b1, 1'b0);
    chk("pre_rst_locked", int'(locked), 1);
    step(1'b1, 4'b0110, 1'b1, 1'b0);
    chk("mid_rst_locked", int'(locked), 0); chk("mid_rst_idx", int'(idx), 0);
    chk("mid_rst_err_onehot", int'(err_onehot), 0);
    step(1'b0, 4'b1000, 1'b1, 1'b0);
    chk("after_rst_locked", int'(locked), 0);
    step(1'b0, 4'b0001, 1'b1, 1'b0);
    step(1'b0, 4'b0010, 1'b1, 1'b0);
    chk("relock_locked", int'(locked), 1); chk("relock_idx", int'(idx), 1);

    step(1'b0, 4'b0000, 1'b0, 1'b0);
    step(1'b0, 4'b0000, 1'b0, 1'b0);
    checking = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
